// File: rtl/sw_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sw_pkg (package)
//  Description : Shared types, DNA symbol codes and saturating arithmetic
//                helpers for the Smith-Waterman affine-gap PE.
//                The helpers work on 32-bit unsigned values, so every
//                parameterised score width up to 31 bits can use them. The
//                caller casts the result back down to its own width.
//  Revision    : 1.0 - initial release
// ============================================================================
package sw_pkg;

    localparam int SYM_W_DEF   = 2;
    localparam int SCORE_W_DEF = 10;

    typedef logic [SYM_W_DEF-1:0]   sym_t;
    typedef logic [SCORE_W_DEF-1:0] score_t;

    // DNA symbol encoding
    localparam sym_t C_SYM_A = 2'd0;
    localparam sym_t C_SYM_C = 2'd1;
    localparam sym_t C_SYM_G = 2'd2;
    localparam sym_t C_SYM_T = 2'd3;

    // a - b, floored at 0
    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

    // a + b, ceiled at maxv
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] maxv);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, maxv}) ? maxv : s[31:0];
    endfunction

    function automatic logic [31:0] max3(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
        logic [31:0] m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sw_score_cell.sv
`default_nettype none
// ============================================================================
//  Module      : sw_score_cell
//  Description : Combinational affine-gap Smith-Waterman cell update.
//                Computes the substitution-adjusted diagonal, E (horizontal
//                gap), F (vertical gap) and the new H score, all saturating.
//  Ports       : t_sym/s_sym   reference / query symbols
//                h_diag        H(i-1,j-1)
//                h_left/e_left H(i,j-1) / E(i,j-1)
//                v_in/f_in     H(i-1,j) / F(i-1,j)
//                e/f/h         resulting E, F, H for cell (i,j)
//  Revision    : 1.0 - initial release
// ============================================================================
module sw_score_cell
    import sw_pkg::*;
#(
    parameter int SYM_W    = 2,
    parameter int SCORE_W  = 10,
    parameter int MATCH    = 2,
    parameter int MISMATCH = 1,
    parameter int GAP_OPEN = 2,
    parameter int GAP_EXT  = 1
) (
    input  logic [SYM_W-1:0]   t_sym,
    input  logic [SYM_W-1:0]   s_sym,
    input  logic [SCORE_W-1:0] h_diag,
    input  logic [SCORE_W-1:0] h_left,
    input  logic [SCORE_W-1:0] e_left,
    input  logic [SCORE_W-1:0] v_in,
    input  logic [SCORE_W-1:0] f_in,
    output logic [SCORE_W-1:0] e,
    output logic [SCORE_W-1:0] f,
    output logic [SCORE_W-1:0] h
);

    localparam logic [31:0] C_MAX = (32'd1 << SCORE_W) - 32'd1;

    logic [31:0] w_diag;
    logic [31:0] w_e;
    logic [31:0] w_f;

    always_comb begin
        w_diag = (t_sym == s_sym) ? sat_add(32'(h_diag), 32'(MATCH), C_MAX)
                                  : sat_sub(32'(h_diag), 32'(MISMATCH));
        w_e    = sat_sub(32'(h_left), 32'(GAP_OPEN));
        w_e    = max3(w_e, sat_sub(32'(e_left), 32'(GAP_EXT)), 32'd0);
        w_f    = sat_sub(32'(v_in), 32'(GAP_OPEN));
        w_f    = max3(w_f, sat_sub(32'(f_in), 32'(GAP_EXT)), 32'd0);
    end

    // Every term is already >= 0, so the max with 0 is implicit.
    assign e = SCORE_W'(w_e);
    assign f = SCORE_W'(w_f);
    assign h = SCORE_W'(max3(w_diag, w_e, w_f));

endmodule
`default_nettype wire

// File: rtl/sw_pe_affine_best.sv
`default_nettype none
// ============================================================================
//  Module      : sw_pe_affine_best
//  Description : Systolic Smith-Waterman PE (affine gaps) with bubble handling
//                and running best-score/position tracking along the chain.
//  Ports       : clk, rst (async, active-high)
//                s_in/store_s        query symbol load (clears alignment state)
//                valid_in, t_in, col_in, v_in, f_in, best_*_in  upstream beat
//                valid_out, t_out, col_out, v_out, f_out, best_*_out
//                                    registered beat toward the next PE
//  Revision    : 1.0 - initial release
// ============================================================================
module sw_pe_affine_best
    import sw_pkg::*;
#(
    parameter int SYM_W    = 2,
    parameter int SCORE_W  = 10,
    parameter int COL_W    = 16,
    parameter int ROW_ID   = 0,
    parameter int MATCH    = 2,
    parameter int MISMATCH = 1,
    parameter int GAP_OPEN = 2,
    parameter int GAP_EXT  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SYM_W-1:0]   s_in,
    input  logic               store_s,
    input  logic               valid_in,
    input  logic [SYM_W-1:0]   t_in,
    input  logic [COL_W-1:0]   col_in,
    input  logic [SCORE_W-1:0] v_in,
    input  logic [SCORE_W-1:0] f_in,
    input  logic [SCORE_W-1:0] best_in,
    input  logic [15:0]        best_row_in,
    input  logic [COL_W-1:0]   best_col_in,
    output logic               valid_out,
    output logic [SYM_W-1:0]   t_out,
    output logic [COL_W-1:0]   col_out,
    output logic [SCORE_W-1:0] v_out,
    output logic [SCORE_W-1:0] f_out,
    output logic [SCORE_W-1:0] best_out,
    output logic [15:0]        best_row_out,
    output logic [COL_W-1:0]   best_col_out
);

    localparam logic [15:0] C_ROW = 16'(ROW_ID);

    logic [SYM_W-1:0]   r_s;
    logic [SCORE_W-1:0] r_h_diag;
    logic [SCORE_W-1:0] r_h_left;
    logic [SCORE_W-1:0] r_e_left;
    logic [SCORE_W-1:0] r_own_best;
    logic [COL_W-1:0]   r_own_col;

    logic [SCORE_W-1:0] w_e;
    logic [SCORE_W-1:0] w_f;
    logic [SCORE_W-1:0] w_h;
    logic               w_upd;
    logic [SCORE_W-1:0] w_best_new;
    logic [COL_W-1:0]   w_col_new;
    logic               w_take_own;

    sw_score_cell #(
        .SYM_W    (SYM_W),
        .SCORE_W  (SCORE_W),
        .MATCH    (MATCH),
        .MISMATCH (MISMATCH),
        .GAP_OPEN (GAP_OPEN),
        .GAP_EXT  (GAP_EXT)
    ) u_cell (
        .t_sym  (t_in),
        .s_sym  (r_s),
        .h_diag (r_h_diag),
        .h_left (r_h_left),
        .e_left (r_e_left),
        .v_in   (v_in),
        .f_in   (f_in),
        .e      (w_e),
        .f      (w_f),
        .h      (w_h)
    );

    // Strict > keeps the earliest column on ties; the chain compare then uses
    // the updated own best, and a tie there keeps the upstream (lower) row.
    assign w_upd      = (w_h > r_own_best);
    assign w_best_new = w_upd ? w_h : r_own_best;
    assign w_col_new  = w_upd ? col_in : r_own_col;
    assign w_take_own = (w_best_new > best_in);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s          <= '0;
            r_h_diag     <= '0;
            r_h_left     <= '0;
            r_e_left     <= '0;
            r_own_best   <= '0;
            r_own_col    <= '0;
            valid_out    <= 1'b0;
            t_out        <= '0;
            col_out      <= '0;
            v_out        <= '0;
            f_out        <= '0;
            best_out     <= '0;
            best_row_out <= '0;
            best_col_out <= '0;
        end else if (store_s) begin
            // A beat arriving together with a load is dropped.
            r_s        <= s_in;
            r_h_diag   <= '0;
            r_h_left   <= '0;
            r_e_left   <= '0;
            r_own_best <= '0;
            r_own_col  <= '0;
            valid_out  <= 1'b0;
        end else if (valid_in) begin
            r_h_diag   <= v_in;
            r_h_left   <= w_h;
            r_e_left   <= w_e;
            r_own_best <= w_best_new;
            r_own_col  <= w_col_new;
            valid_out  <= 1'b1;
            t_out      <= t_in;
            col_out    <= col_in;
            v_out      <= w_h;
            f_out      <= w_f;
            if (w_take_own) begin
                best_out     <= w_best_new;
                best_row_out <= C_ROW;
                best_col_out <= w_col_new;
            end else begin
                best_out     <= best_in;
                best_row_out <= best_row_in;
                best_col_out <= best_col_in;
            end
        end else begin
            // Bubble: only the valid flag drops, everything else holds.
            valid_out <= 1'b0;
        end
    end

endmodule
`default_nettype wire
